// File: rtl/culsans_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// culsans_pkg: Culsans SoC address map and address-decoder rule types.
// Revision: 1.0
// ------------------------------------------------------------------------
package culsans_pkg;

  localparam int unsigned NB_PERIPHERALS = 10;

  typedef enum logic [63:0] {
    DebugBase    = 64'h0000_0000,
    ROMBase      = 64'h0001_0000,
    CLINTBase    = 64'h0200_0000,
    PLICBase     = 64'h0C00_0000,
    UARTBase     = 64'h1000_0000,
    TimerBase    = 64'h1800_0000,
    SPIBase      = 64'h2000_0000,
    EthernetBase = 64'h3000_0000,
    GPIOBase     = 64'h4000_0000,
    DRAMBase     = 64'h8000_0000
  } soc_bus_start_t;

  localparam logic [63:0] DebugLength    = 64'h1000;
  localparam logic [63:0] ROMLength      = 64'h1_0000;
  localparam logic [63:0] CLINTLength    = 64'hC_0000;
  localparam logic [63:0] PLICLength     = 64'h3FF_FFFF;
  localparam logic [63:0] UARTLength     = 64'h1000;
  localparam logic [63:0] TimerLength    = 64'h1000;
  localparam logic [63:0] SPILength      = 64'h80_0000;
  localparam logic [63:0] EthernetLength = 64'h1_0000;
  localparam logic [63:0] GPIOLength     = 64'h1000;
  localparam logic [63:0] DRAMLength     = 64'h4000_0000;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
  } dec_rule_t;

  function automatic int unsigned dec_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DecNumRules = NB_PERIPHERALS;

  // Index order: 0=DRAM 1=GPIO 2=Ethernet 3=SPI 4=Timer 5=UART 6=PLIC 7=CLINT 8=ROM 9=Debug
  localparam logic [DecNumRules-1:0][63:0] DecInitBase = {
    DebugBase, ROMBase, CLINTBase, PLICBase, UARTBase,
    TimerBase, SPIBase, EthernetBase, GPIOBase, DRAMBase
  };

  localparam logic [DecNumRules-1:0][63:0] DecInitLen = {
    DebugLength, ROMLength, CLINTLength, PLICLength, UARTLength,
    TimerLength, SPILength, EthernetLength, GPIOLength, DRAMLength
  };

endpackage
`default_nettype wire

// File: rtl/culsans_addr_match.sv
`default_nettype none
// ------------------------------------------------------------------------
// culsans_addr_match: combinational rule matcher, lowest index wins.
// Revision: 1.0
// ------------------------------------------------------------------------
module culsans_addr_match
  import culsans_pkg::*;
#(
  parameter int unsigned  NumRules  = 10,
  parameter int unsigned  AddrWidth = 64,
  localparam int unsigned IdxWidth  = dec_idx_width(NumRules)
) (
  input  logic [AddrWidth-1:0]     addr_i,
  input  dec_rule_t [NumRules-1:0] rules_i,
  output logic [IdxWidth-1:0]      idx_o,
  output logic                     hit_o
);

  logic [NumRules-1:0] match;

  for (genvar i = 0; i < NumRules; i++) begin : g_rule
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] len;
    logic [AddrWidth:0]   limit;

    assign base  = rules_i[i].base[AddrWidth-1:0];
    assign len   = rules_i[i].len[AddrWidth-1:0];
    // One extra bit so a region ending at the top of the space never wraps.
    assign limit = {1'b0, base} + {1'b0, len};
    assign match[i] = (len != '0) && (addr_i >= base) && ({1'b0, addr_i} < limit);
  end

  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx_o = IdxWidth'(i);
        hit_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/culsans_addr_decoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// culsans_addr_decoder: programmable registered address decoder; hit/miss
// counters enabled with CULSANS_DEC_PERF_EN.  Revision: 1.0
// ------------------------------------------------------------------------
module culsans_addr_decoder
  import culsans_pkg::*;
#(
  parameter int unsigned  NumRules  = 10,
  parameter int unsigned  AddrWidth = 64,
  parameter int unsigned  CntWidth  = 32,
  parameter logic [NumRules-1:0][AddrWidth-1:0] InitBase = '0,
  parameter logic [NumRules-1:0][AddrWidth-1:0] InitLen  = '0,
  localparam int unsigned IdxWidth  = dec_idx_width(NumRules)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [AddrWidth-1:0] rsp_addr_o,
  output logic [IdxWidth-1:0]  rsp_idx_o,
  output logic                 rsp_hit_o
`ifdef CULSANS_DEC_PERF_EN
  ,
  input  logic                               cnt_clr_i,
  output logic [NumRules-1:0][CntWidth-1:0]  hit_cnt_o,
  output logic [CntWidth-1:0]                miss_cnt_o
`endif
);

  logic [NumRules-1:0][AddrWidth-1:0] base_q;
  logic [NumRules-1:0][AddrWidth-1:0] len_q;
  dec_rule_t [NumRules-1:0]           rules;
  logic [IdxWidth-1:0]                match_idx;
  logic                               match_hit;
  logic                               accept;

  logic                 rsp_valid_q;
  logic [AddrWidth-1:0] rsp_addr_q;
  logic [IdxWidth-1:0]  rsp_idx_q;
  logic                 rsp_hit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= InitBase;
      len_q  <= InitLen;
    end else if (cfg_we_i) begin
      for (int unsigned i = 0; i < NumRules; i++) begin
        if (cfg_idx_i == IdxWidth'(i)) begin
          base_q[i] <= cfg_base_i;
          len_q[i]  <= cfg_len_i;
        end
      end
    end
  end

  for (genvar i = 0; i < NumRules; i++) begin : g_rules
    assign rules[i].base = 64'(base_q[i]);
    assign rules[i].len  = 64'(len_q[i]);
  end

  culsans_addr_match #(
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth)
  ) i_match (
    .addr_i  (req_addr_i),
    .rules_i (rules),
    .idx_o   (match_idx),
    .hit_o   (match_hit)
  );

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_idx_q   <= '0;
      rsp_hit_q   <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_addr_q  <= req_addr_i;
      rsp_idx_q   <= match_idx;
      rsp_hit_q   <= match_hit;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_hit_o   = rsp_hit_q;

`ifdef CULSANS_DEC_PERF_EN
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic                              rsp_hs;
  logic [NumRules-1:0][CntWidth-1:0] hit_cnt_q;
  logic [CntWidth-1:0]               miss_cnt_q;

  assign rsp_hs = rsp_valid_q && rsp_ready_i;

  // Clear wins over a coincident increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rsp_hs) begin
      if (!rsp_hit_q) begin
        if (miss_cnt_q != CntMax) miss_cnt_q <= miss_cnt_q + CntWidth'(1);
      end else begin
        for (int unsigned i = 0; i < NumRules; i++) begin
          if (rsp_idx_q == IdxWidth'(i) && hit_cnt_q[i] != CntMax) begin
            hit_cnt_q[i] <= hit_cnt_q[i] + CntWidth'(1);
          end
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_culsans_addr_decoder.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_culsans_addr_decoder: directed self-checking bench for the decoder.
// Revision: 1.0
// ------------------------------------------------------------------------
module tb_culsans_addr_decoder;
  import culsans_pkg::*;

  localparam int unsigned NR = DecNumRules;
  localparam int unsigned IW = dec_idx_width(NR);

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cfg_we    = 1'b0;
  logic [IW-1:0] cfg_idx   = '0;
  logic [63:0]   cfg_base  = '0;
  logic [63:0]   cfg_len   = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [63:0]   req_addr  = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [63:0]   rsp_addr;
  logic [IW-1:0] rsp_idx;
  logic          rsp_hit;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

`ifdef CULSANS_DEC_PERF_EN
  logic                  cnt_clr = 1'b0;
  logic [NR-1:0][31:0]   hit_cnt;
  logic [31:0]           miss_cnt;
  logic                  s_req_ready, s_rsp_valid, s_rsp_hit;
  logic [63:0]           s_rsp_addr;
  logic [IW-1:0]         s_rsp_idx;
  logic [NR-1:0][1:0]    s_hit_cnt;
  logic [1:0]            s_miss_cnt;
  int                    exp_hit [NR];
  int                    exp_miss;
`endif

  culsans_addr_decoder #(
    .NumRules  (NR),
    .AddrWidth (64),
    .CntWidth  (32),
    .InitBase  (DecInitBase),
    .InitLen   (DecInitLen)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_base_i  (cfg_base),
    .cfg_len_i   (cfg_len),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_addr_o  (rsp_addr),
    .rsp_idx_o   (rsp_idx),
    .rsp_hit_o   (rsp_hit)
`ifdef CULSANS_DEC_PERF_EN
    ,
    .cnt_clr_i   (cnt_clr),
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

`ifdef CULSANS_DEC_PERF_EN
  // Same stimulus, 2-bit counters to exercise saturation.
  culsans_addr_decoder #(
    .NumRules  (NR),
    .AddrWidth (64),
    .CntWidth  (2),
    .InitBase  (DecInitBase),
    .InitLen   (DecInitLen)
  ) dut_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_base_i  (cfg_base),
    .cfg_len_i   (cfg_len),
    .req_valid_i (req_valid),
    .req_ready_o (s_req_ready),
    .req_addr_i  (req_addr),
    .rsp_valid_o (s_rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_addr_o  (s_rsp_addr),
    .rsp_idx_o   (s_rsp_idx),
    .rsp_hit_o   (s_rsp_hit),
    .cnt_clr_i   (cnt_clr),
    .hit_cnt_o   (s_hit_cnt),
    .miss_cnt_o  (s_miss_cnt)
  );
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef CULSANS_DEC_PERF_EN
  task automatic model_clear();
    for (int i = 0; i < NR; i++) exp_hit[i] = 0;
    exp_miss = 0;
  endtask

  task automatic model_result(input int idx, input bit hit);
    if (hit) exp_hit[idx]++;
    else exp_miss++;
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_hit%0d", tag, i), 64'(hit_cnt[i]), 64'(exp_hit[i]));
      check($sformatf("%s_sathit%0d", tag, i), 64'(s_hit_cnt[i]),
            64'((exp_hit[i] > 3) ? 3 : exp_hit[i]));
    end
    check({tag, "_miss"}, 64'(miss_cnt), 64'(exp_miss));
    check({tag, "_satmiss"}, 64'(s_miss_cnt), 64'((exp_miss > 3) ? 3 : exp_miss));
  endtask
`endif

  task automatic cfg_write(input int idx, input logic [63:0] base, input logic [63:0] len);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_base = base;
    cfg_len  = len;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Accept one request, check the registered result, then hand it off.
  task automatic decode(input string tag, input logic [63:0] a, input int e_idx, input bit e_hit);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_idx"},   64'(rsp_idx),   64'(e_idx));
    check({tag, "_hit"},   64'(rsp_hit),   64'(e_hit));
    check({tag, "_addr"},  rsp_addr,       a);
    tick();
`ifdef CULSANS_DEC_PERF_EN
    model_result(e_idx, e_hit);
`endif
  endtask

  initial begin
`ifdef CULSANS_DEC_PERF_EN
    model_clear();
`endif
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_addr",  rsp_addr,       64'd0);
    check("rst_idx",   64'(rsp_idx),   64'd0);
    check("rst_hit",   64'(rsp_hit),   64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
`ifdef CULSANS_DEC_PERF_EN
    check_counters("rst");
`endif

    decode("uart",  64'h1000_0800, 5, 1'b1);
    decode("dram",  64'h8000_0000, 0, 1'b1);
    decode("miss",  64'h5000_0000, 0, 1'b0);
    decode("debug", 64'h0000_0FFF, 9, 1'b1);
`ifdef CULSANS_DEC_PERF_EN
    check_counters("map");
`endif

    cfg_write(3, 64'hFFFF_FFFF_FFFF_F000, 64'h1000);
    decode("top",      64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b1);
    decode("below",    64'hFFFF_FFFF_FFFF_EFFF, 0, 1'b0);
    decode("uart_end", 64'h1000_1000,           0, 1'b0);
    decode("old_spi",  64'h2000_0000,           0, 1'b0);

    cfg_write(2, 64'h1000_0000, 64'h10);
    decode("ovl_in",   64'h1000_0004, 2, 1'b1);
    decode("ovl_past", 64'h1000_0010, 5, 1'b1);

    // Disabling write in the same cycle as an accept: old table applies.
    cfg_we    = 1'b1;
    cfg_idx   = IW'(2);
    cfg_base  = 64'h1000_0000;
    cfg_len   = 64'h0;
    req_valid = 1'b1;
    req_addr  = 64'h1000_0004;
    rsp_ready = 1'b1;
    tick();
    cfg_we    = 1'b0;
    req_valid = 1'b0;
    check("race_idx", 64'(rsp_idx), 64'd2);
    check("race_hit", 64'(rsp_hit), 64'd1);
    tick();
`ifdef CULSANS_DEC_PERF_EN
    model_result(2, 1'b1);
`endif
    decode("race_new", 64'h1000_0004, 5, 1'b1);

    // Backpressure: first request held, second stalls.
    req_valid = 1'b1;
    req_addr  = 64'h8000_0040;
    rsp_ready = 1'b0;
    tick();
    req_addr  = 64'h1000_0008;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
      check($sformatf("bp_valid%0d", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_addr%0d", c),  rsp_addr,       64'h8000_0040);
      check($sformatf("bp_idx%0d", c),   64'(rsp_idx),   64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_ready_rel", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    check("bp2_valid", 64'(rsp_valid), 64'd1);
    check("bp2_addr",  rsp_addr,       64'h1000_0008);
    check("bp2_idx",   64'(rsp_idx),   64'd5);
    tick();
    check("bp_drain", 64'(rsp_valid), 64'd0);
`ifdef CULSANS_DEC_PERF_EN
    model_result(0, 1'b1);
    model_result(5, 1'b1);
    check_counters("bp");

    for (int k = 0; k < 3; k++) decode("cnt", 64'h1000_0000, 5, 1'b1);
    check_counters("pre_clr");
    req_valid = 1'b1;
    req_addr  = 64'h1000_0000;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    cnt_clr   = 1'b1;
    tick();
    cnt_clr   = 1'b0;
    model_clear();
    check_counters("clr");

    for (int k = 0; k < 5; k++) decode("sat", 64'h1000_0000, 5, 1'b1);
    check_counters("sat");
`endif

    // Reset with a result pending.
    req_valid = 1'b1;
    req_addr  = 64'h4000_0000;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("pend_valid", 64'(rsp_valid), 64'd1);
    check("pend_idx",   64'(rsp_idx),   64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_idx",   64'(rsp_idx),   64'd0);
    check("mid_rst_addr",  rsp_addr,       64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
`ifdef CULSANS_DEC_PERF_EN
    model_clear();
    check_counters("mid_rst");
`endif
    decode("spi_restored", 64'h2000_0000, 3, 1'b1);

    cfg_write(5, 64'h1000_0000, 64'h0);
    decode("uart_off", 64'h1000_0800, 0, 1'b0);
    cfg_write(12, 64'h1000_0000, 64'h1000);
    decode("bad_idx",  64'h1000_0800, 0, 1'b0);
`ifdef CULSANS_DEC_PERF_EN
    check_counters("final");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/culsans_addr_decoder.md
# culsans_addr_decoder

Runtime-programmable, registered address decoder that maps a request address to one of `NumRules` slave indices, with optional per-rule hit counters. It generalises the fixed Culsans SoC address map: rule count and address width are parameters, the rule table is writable at run time, and results leave through a one-entry valid/ready pipeline stage. It sits in front of the crossbar demux and the cached/shared-region classification logic.

## Interface
- `NumRules`, 10: number of rules; the Culsans peripheral count.
- `AddrWidth`, 64: address width.
- `CntWidth`, 32: hit-counter width.
- `InitBase`, all zeros: `[NumRules][AddrWidth]` base value loaded at reset.
- `InitLen`, all zeros: `[NumRules][AddrWidth]` length value loaded at reset.
- `IdxWidth`, derived: `max(1, $clog2(NumRules))`. Not to be overridden.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `cfg_we_i` in 1: rule write strobe.
- `cfg_idx_i` in IdxWidth: rule to write. Writes with an index ≥ NumRules are ignored.
- `cfg_base_i` in AddrWidth: new base.
- `cfg_len_i` in AddrWidth: new length. 0 disables the rule.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_addr_i` in AddrWidth: address to decode.
- `rsp_valid_o` out 1: result valid.
- `rsp_ready_i` in 1: result accepted.
- `rsp_addr_o` out AddrWidth: registered copy of the address.
- `rsp_idx_o` out IdxWidth: matched rule. 0 on miss.
- `rsp_hit_o` out 1: 1 = matched, 0 = decode error.
- `cnt_clr_i` in 1: clear all counters. Present only with `CULSANS_DEC_PERF_EN`.
- `hit_cnt_o` out `[NumRules][CntWidth]`: per-rule hit counts. Present only with `CULSANS_DEC_PERF_EN`.
- `miss_cnt_o` out CntWidth: decode-error count. Present only with `CULSANS_DEC_PERF_EN`.

## Operation
- **Match rule.** Rule `i` matches when `len[i] != 0` and `base[i] <= addr < base[i] + len[i]`.
  - The sum is computed at AddrWidth+1 bits, so a rule ending exactly at 2^AddrWidth matches the top address and never wraps.
- **Priority.** On overlapping rules, the lowest index wins.
- **Reset.** Table loads `InitBase` / `InitLen`.
- **Config write.** Takes effect the cycle after `cfg_we_i`.
  - A request accepted in the same cycle as a write decodes against the old table.
  - A result already held in the output stage is never altered by a write.
- **Pipeline.** One output register.
  - `req_ready_o = !rsp_valid_o || rsp_ready_i`.
  - On `req_valid_i && req_ready_o`, the register captures addr, idx and hit, and sets `rsp_valid_o`.
  - Otherwise a handshake on `rsp_valid_o && rsp_ready_i` clears `rsp_valid_o`.
  - While `rsp_valid_o && !rsp_ready_i`, all `rsp_*` outputs hold stable.
- **Reset values.**
  - `rsp_valid_o` = 0, `rsp_addr_o` = 0, `rsp_idx_o` = 0, `rsp_hit_o` = 0.
  - All counters = 0.
  - `req_ready_o` = 1 in the first cycle after reset.
- **Reset mid-operation.** A pending result is dropped and not counted.

## Timing
- Latency is 1 cycle from request acceptance to `rsp_valid_o`.
- Throughput is 1 per cycle while `rsp_ready_i` stays high.
- `req_ready_o` depends combinationally on `rsp_ready_i`. This is the only comb path from input to output.
- Match and priority logic is combinational within the accept cycle. The rule-table read is not registered.
- Counter update:
  - Counters update on the output handshake edge, and are visible the next cycle.
  - Counters saturate at `2^CntWidth-1`.
  - `cnt_clr_i` has priority over a simultaneous increment; the result is 0.

## Configuration
- Macro `CULSANS_DEC_PERF_EN`.
- **Defined:** `cnt_clr_i`, `hit_cnt_o` and `miss_cnt_o` exist.
  - `hit_cnt_o[i]` increments on each handshaked result with hit = 1 and idx = i.
  - `miss_cnt_o` increments on each handshaked result with hit = 0.
- **Undefined:** those ports and their registers are absent. Decode behaviour is identical.

## Structure
- `culsans_pkg` gains:
  - `dec_rule_t` struct with `base` and `len` fields, each `logic [63:0]`.
  - localparam `DecNumRules = NB_PERIPHERALS`.
  - localparams `DecInitBase` / `DecInitLen`, built from `soc_bus_start_t` and the `*Length` constants.
- One sub-module, `culsans_addr_match`: combinational. Inputs are the address and the rule array; outputs are idx and hit, with lowest-index priority. It is reused by the cached/shared-region classifiers.

## Test plan
- **Reset map hit.** Reset with the Culsans map, send addr 0x1000_0800 → after 1 cycle idx=5 (UART), hit=1. Send 0x8000_0000 → idx=0 (DRAM).
- **Miss.** Send 0x5000_0000 → hit=0, idx=0. With PERF enabled, `miss_cnt_o` = 1 after the handshake.
- **Boundary and wrap.**
  - Write rule 3 with base 0xFFFF_FFFF_FFFF_F000, len 0x1000. Addr 0xFFFF_FFFF_FFFF_FFFF → idx=3.
  - Addr 0x1000_1000 → miss (one past the UART end).
  - Set rule 5 len=0 → UART addresses miss.
- **Overlap and write race.**
  - Rule 2 covers 0x1000_0000 with len 0x10 → addr 0x1000_0004 gives idx=2.
  - A write to rule 2 in the same cycle as that accept still uses the old table.
- **Backpressure.** Hold `rsp_ready_i`=0 for 5 cycles with `req_valid_i`=1.
  - `req_ready_o`=0 from the second request onward, and outputs stay stable.
  - After release, results arrive in order with no loss or duplicate.
  - Counters increment once per result.
- **Counters** (with `CULSANS_DEC_PERF_EN`):
  - Run 3 handshaked hits to rule 5; assert `cnt_clr_i` together with a 4th hit → `hit_cnt_o[5]`=0 next cycle.
  - With CntWidth=2, run 5 hits → saturates at 3.
  - Assert `rst_i` while a result is pending → `rsp_valid_o`=0 and counters are 0.
